// File: rtl/endgame_fade_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : endgame_fade_ctrl_if
//  Description : Pixel/control bundle between the palette lookup, the fade
//                controller and the VGA output register.
//  Revision    : 1.0 - initial release
// ============================================================================
interface endgame_fade_ctrl_if;
    logic       frame_start;
    logic       trigger;
    logic [1:0] scene_req;
    logic       blank_in;
    logic [3:0] red_in;
    logic [3:0] green_in;
    logic [3:0] blue_in;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic [1:0] scene_sel;
    logic       busy;
    logic       done;

    modport master (
        output frame_start, trigger, scene_req, blank_in, red_in, green_in, blue_in,
        input  red, green, blue, scene_sel, busy, done
    );

    modport slave (
        input  frame_start, trigger, scene_req, blank_in, red_in, green_in, blue_in,
        output red, green, blue, scene_sel, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/endgame_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : endgame_fade_ctrl
//  Description : Full-screen fade-out / black hold / fade-in sequencer that
//                scales palette RGB by a frame-stepped brightness level and
//                switches the scene select while the screen is black.
//  Revision    : 1.0 - initial release
// ============================================================================
module endgame_fade_ctrl #(
    parameter int STEP_FRAMES = 4,
    parameter int HOLD_FRAMES = 8
) (
    input  wire                 clk,
    input  wire                 reset_n,
    endgame_fade_ctrl_if.slave  bus
);

    localparam int c_MAX_FRAMES = (STEP_FRAMES > HOLD_FRAMES) ? STEP_FRAMES : HOLD_FRAMES;
    localparam int c_FCNT_W     = (c_MAX_FRAMES > 1) ? $clog2(c_MAX_FRAMES) : 1;

    localparam logic [c_FCNT_W-1:0] c_STEP_LAST = c_FCNT_W'(STEP_FRAMES - 1);
    localparam logic [c_FCNT_W-1:0] c_HOLD_LAST = c_FCNT_W'(HOLD_FRAMES - 1);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_FADE_OUT = 2'd1;
    localparam logic [1:0] c_S_HOLD     = 2'd2;
    localparam logic [1:0] c_S_FADE_IN  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [3:0]          r_level;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic [1:0]          r_scene_lat;
    logic [1:0]          r_scene_sel;
    logic                r_done;
    logic [3:0]          r_red;
    logic [3:0]          r_green;
    logic [3:0]          r_blue;
    logic                w_busy;
    logic                w_finish;
    logic                w_step_last;
    logic                w_hold_last;

    // Brightness scale: upper nibble of c * (level + 1); level 15 is identity.
    function automatic logic [3:0] f_scale(input logic [3:0] c, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'd0, c} * ({4'd0, lvl} + 8'd1);
        return prod[7:4];
    endfunction

    assign w_step_last = (r_fcnt == c_STEP_LAST);
    assign w_hold_last = (r_fcnt == c_HOLD_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; every move except the trigger happens on a frame_start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (bus.trigger) w_state_nxt = c_S_FADE_OUT;
            end
            c_S_FADE_OUT: begin
                if (bus.frame_start && w_step_last && (r_level == 4'd1)) w_state_nxt = c_S_HOLD;
            end
            c_S_HOLD: begin
                if (bus.frame_start && w_hold_last) w_state_nxt = c_S_FADE_IN;
            end
            default: begin
                if (bus.frame_start && w_step_last && (r_level == 4'd14)) w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State-derived outputs: busy and the end-of-transition strobe.
    always_comb begin
        w_busy   = (r_state != c_S_IDLE);
        w_finish = (r_state == c_S_FADE_IN) && (w_state_nxt == c_S_IDLE);
    end

    // Frame counter, brightness level, scene latch/select and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level     <= 4'd15;
            r_fcnt      <= '0;
            r_scene_lat <= 2'd0;
            r_scene_sel <= 2'd0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                c_S_IDLE: begin
                    r_level <= 4'd15;
                    if (bus.trigger) begin
                        r_scene_lat <= bus.scene_req;
                        r_fcnt      <= '0;
                    end
                end
                c_S_FADE_OUT: begin
                    if (bus.frame_start) begin
                        if (w_step_last) begin
                            r_fcnt  <= '0;
                            r_level <= r_level - 4'd1;
                            // Screen is black from this frame on: safe to swap scenes.
                            if (r_level == 4'd1) r_scene_sel <= r_scene_lat;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
                c_S_HOLD: begin
                    if (bus.frame_start) begin
                        if (w_hold_last) r_fcnt <= '0;
                        else             r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: begin
                    if (bus.frame_start) begin
                        if (w_step_last) begin
                            r_fcnt  <= '0;
                            r_level <= r_level + 4'd1;
                        end else begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Registered colour path, forced black outside the visible area.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red   <= 4'd0;
            r_green <= 4'd0;
            r_blue  <= 4'd0;
        end else if (bus.blank_in) begin
            r_red   <= 4'd0;
            r_green <= 4'd0;
            r_blue  <= 4'd0;
        end else begin
            r_red   <= f_scale(bus.red_in,   r_level);
            r_green <= f_scale(bus.green_in, r_level);
            r_blue  <= f_scale(bus.blue_in,  r_level);
        end
    end

    assign bus.red       = r_red;
    assign bus.green     = r_green;
    assign bus.blue      = r_blue;
    assign bus.scene_sel = r_scene_sel;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_endgame_fade_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_endgame_fade_ctrl
//  Description : Directed self-checking bench for endgame_fade_ctrl, default
//                parameters plus a STEP_FRAMES=1 / HOLD_FRAMES=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_endgame_fade_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    endgame_fade_ctrl_if bus  ();
    endgame_fade_ctrl_if busf ();

    endgame_fade_ctrl #(.STEP_FRAMES(4), .HOLD_FRAMES(8)) u_dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    endgame_fade_ctrl #(.STEP_FRAMES(1), .HOLD_FRAMES(1)) u_dut_fast (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (busf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected brightness after i counted frame_starts.
    function automatic int exp_level(input int i, input int s, input int h);
        if (i <= 15 * s)          return 15 - i / s;
        else if (i <= 15 * s + h) return 0;
        else                      return (i - 15 * s - h) / s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
    endtask

    task automatic frame_f();
        busf.frame_start = 1'b1;
        step();
        busf.frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.red_in = 4'hA; bus.green_in = 4'h5; bus.blue_in = 4'hC;
        step(); step();
        n_checks++; if ({bus.red, bus.green, bus.blue} !== 12'h000) $display("FAIL reset_rgb got=%h exp=000", {bus.red, bus.green, bus.blue}); else n_pass++;
        n_checks++; if (bus.scene_sel !== 2'd0) $display("FAIL reset_scene got=%0d exp=0", bus.scene_sel); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b exp=0", bus.done); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        bus.red_in = 4'hE; bus.green_in = 4'h1; bus.blue_in = 4'h0; bus.blank_in = 1'b0;
        step();
        n_checks++; if ({bus.red, bus.green, bus.blue} !== 12'hE10) $display("FAIL passthrough got=%h exp=e10", {bus.red, bus.green, bus.blue}); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL pass_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if (bus.scene_sel !== 2'd0) $display("FAIL pass_scene got=%0d exp=0", bus.scene_sel); else n_pass++;
        bus.red_in = 4'h3;
        #1;
        n_checks++; if (bus.red !== 4'hE) $display("FAIL pass_latency got=%h exp=e", bus.red); else n_pass++;
        step();
    endtask

    task automatic test_blanking();
        bus.red_in = 4'hF; bus.green_in = 4'hF; bus.blue_in = 4'hF; bus.blank_in = 1'b1;
        step();
        n_checks++; if ({bus.red, bus.green, bus.blue} !== 12'h000) $display("FAIL blank got=%h exp=000", {bus.red, bus.green, bus.blue}); else n_pass++;
        bus.blank_in = 1'b0;
        step();
        n_checks++; if ({bus.red, bus.green, bus.blue} !== 12'hFFF) $display("FAIL unblank got=%h exp=fff", {bus.red, bus.green, bus.blue}); else n_pass++;
    endtask

    // One default-parameter transition with per-frame expectations.
    task automatic run_transition(input logic [1:0] req, input logic [1:0] prev,
                                  input bit coincident, input bit inject);
        bus.red_in = 4'h8; bus.green_in = 4'hF; bus.blue_in = 4'h0; bus.blank_in = 1'b0;
        bus.scene_req = req; bus.trigger = 1'b1;
        if (coincident) bus.frame_start = 1'b1;
        step();
        bus.trigger = 1'b0; bus.frame_start = 1'b0; bus.scene_req = 2'd0;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL busy_after_trigger got=%b exp=1", bus.busy); else n_pass++;
        for (int i = 1; i <= 128; i++) begin
            if (inject && i == 5) begin
                bus.trigger = 1'b1; bus.scene_req = 2'd3;
                step();
                bus.trigger = 1'b0; bus.scene_req = 2'd0;
            end
            frame();
            n_checks++; if (bus.done !== (i == 128)) $display("FAIL done frame=%0d got=%b exp=%b", i, bus.done, (i == 128)); else n_pass++;
            n_checks++; if (bus.busy !== (i != 128)) $display("FAIL busy frame=%0d got=%b exp=%b", i, bus.busy, (i != 128)); else n_pass++;
            n_checks++; if (bus.scene_sel !== ((i >= 60) ? req : prev)) $display("FAIL scene_sel frame=%0d got=%0d exp=%0d", i, bus.scene_sel, ((i >= 60) ? req : prev)); else n_pass++;
            step();
            n_checks++; if (bus.green !== 4'(exp_level(i, 4, 8))) $display("FAIL level frame=%0d got=%0d exp=%0d", i, bus.green, exp_level(i, 4, 8)); else n_pass++;
            if (i == 16) begin
                n_checks++; if (bus.red !== 4'd6) $display("FAIL scale_8_at_11 got=%0d exp=6", bus.red); else n_pass++;
            end
            if (i == 60) begin
                n_checks++; if ({bus.red, bus.green} !== 8'h00) $display("FAIL black_at_60 got=%h exp=00", {bus.red, bus.green}); else n_pass++;
            end
            if (i == 128) begin
                n_checks++; if (bus.done !== 1'b0) $display("FAIL done_width got=%b exp=0", bus.done); else n_pass++;
                n_checks++; if (bus.red !== 4'h8) $display("FAIL full_after_done got=%h exp=8", bus.red); else n_pass++;
            end
        end
    endtask

    task automatic test_full_transition();
        run_transition(2'd2, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_trigger();
        run_transition(2'd1, 2'd2, 1'b0, 1'b1);
    endtask

    task automatic test_coincident_trigger();
        run_transition(2'd0, 2'd1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_hold();
        bus.red_in = 4'h8; bus.green_in = 4'hF; bus.blue_in = 4'hF; bus.blank_in = 1'b0;
        bus.scene_req = 2'd3; bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        for (int i = 1; i <= 62; i++) frame();
        n_checks++; if (bus.scene_sel !== 2'd3) $display("FAIL hold_scene got=%0d exp=3", bus.scene_sel); else n_pass++;
        bus.frame_start = 1'b1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL async_busy got=%b exp=0", bus.busy); else n_pass++;
        n_checks++; if (bus.scene_sel !== 2'd0) $display("FAIL async_scene got=%0d exp=0", bus.scene_sel); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL async_done got=%b exp=0", bus.done); else n_pass++;
        step();
        bus.frame_start = 1'b0;
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.green !== 4'd15) $display("FAIL level_after_reset got=%0d exp=15", bus.green); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            frame();
            n_checks++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL post_reset_idle got=%b exp=00", {bus.busy, bus.done}); else n_pass++;
        end
    endtask

    // Fastest parameters, with a second trigger landing in the done cycle.
    task automatic test_fast_params();
        busf.red_in = 4'h8; busf.green_in = 4'hF; busf.blue_in = 4'h0; busf.blank_in = 1'b0;
        busf.scene_req = 2'd1; busf.trigger = 1'b1;
        step();
        busf.trigger = 1'b0; busf.scene_req = 2'd0;
        n_checks++; if (busf.busy !== 1'b1) $display("FAIL fast_busy_start got=%b exp=1", busf.busy); else n_pass++;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 31; i++) begin
                frame_f();
                n_checks++; if (busf.done !== (i == 31)) $display("FAIL fast_done run=%0d frame=%0d got=%b exp=%b", r, i, busf.done, (i == 31)); else n_pass++;
                n_checks++; if (busf.scene_sel !== ((r == 0) ? ((i >= 15) ? 2'd1 : 2'd0) : ((i >= 15) ? 2'd2 : 2'd1)))
                    $display("FAIL fast_scene run=%0d frame=%0d got=%0d", r, i, busf.scene_sel); else n_pass++;
                if (i == 31 && r == 0) begin
                    busf.trigger = 1'b1; busf.scene_req = 2'd2;
                end
                step();
                busf.trigger = 1'b0; busf.scene_req = 2'd0;
                n_checks++; if (busf.green !== 4'(exp_level(i, 1, 1))) $display("FAIL fast_level run=%0d frame=%0d got=%0d exp=%0d", r, i, busf.green, exp_level(i, 1, 1)); else n_pass++;
                if (i == 31) begin
                    n_checks++; if (busf.busy !== (r == 0)) $display("FAIL back_to_back run=%0d got=%b exp=%b", r, busf.busy, (r == 0)); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.frame_start  = 1'b0; bus.trigger  = 1'b0; bus.scene_req  = 2'd0; bus.blank_in  = 1'b0;
        bus.red_in       = 4'h0; bus.green_in = 4'h0; bus.blue_in    = 4'h0;
        busf.frame_start = 1'b0; busf.trigger = 1'b0; busf.scene_req = 2'd0; busf.blank_in = 1'b0;
        busf.red_in      = 4'h0; busf.green_in = 4'h0; busf.blue_in  = 4'h0;
        #1;
        test_reset();
        test_passthrough();
        test_blanking();
        test_full_transition();
        test_ignored_trigger();
        test_coincident_trigger();
        test_reset_mid_hold();
        test_fast_params();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
